rr_channel_mux: RTL and testbench
=================================

Name: rr_channel_mux

Overview:
- Round-robin N-to-1 channel multiplexer with a registered output stage; the sending-side counterpart of the 1-to-4 demultiplexer.
- Collects words from NUM_CH independent valid/ready input channels and serialises them onto one output stream.
- Each output word is tagged with its source channel index (out_sel), so a downstream demux can route the word back to the matching output y[out_sel].

Parameters:
- DATA_W, 8, width of each channel's data word.
- NUM_CH, 4, number of input channels; must be a power of 2 and at least 2.
- SEL_W, $clog2(NUM_CH) = 2, width of the channel tag. Derived; never overridden.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel data-valid.
- in_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered word.
- out_sel  output  SEL_W  source channel of out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is forced to 0 while rst=1.
- Transfers:
  - Input transfer on channel k when in_valid[k] && in_ready[k] at a rising edge.
  - Output transfer when out_valid && out_ready.
- load_ok = !out_valid || out_ready. The register may load in the same cycle it drains, so sustained throughput is 1 word per clock.
- Arbitration (combinational):
  - g = first k with in_valid[k]=1, searching from rr_ptr upward modulo NUM_CH.
  - in_ready[g] = load_ok; all other in_ready bits are 0.
  - If no channel is valid, in_ready = 0.
- On an input transfer from g:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- Output transfer with no input transfer: out_valid <= 0. out_data and out_sel hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_sel and rr_ptr are frozen and in_ready = 0.
- rr_ptr advances only on an input transfer. It does not move on idle cycles or on output-only transfers.
- Latency: input transfer at edge N gives out_valid=1 after edge N, i.e. 1 cycle.
- in_valid dropping without a transfer is legal. The arbiter re-evaluates each cycle, and no grant lock is held.
- Reset mid-operation: a held word is discarded (out_valid=0 next cycle) and rr_ptr returns to 0.
- No word is dropped or duplicated. The count of input transfers equals the count of output transfers plus out_valid.

Optional Feature:
- Macro: RR_CHANNEL_MUX_CH0_PRIO_EN.
- Defined:
  - Channel 0 has strict priority. When in_valid[0]=1, g=0 regardless of rr_ptr.
  - A grant to channel 0 does not update rr_ptr.
  - Channels 1..NUM_CH-1 are round-robin among themselves. rr_ptr skips channel 0 and wraps from NUM_CH-1 to 1.
- Undefined: pure round-robin exactly as described in Behaviour.

Decomposition:
- Package mux_pkg holds:
  - DATA_W default and NUM_CH default.
  - SEL_W derived as $clog2(NUM_CH).
  - Typedef chan_sel_t = logic [SEL_W-1:0].
  - The same package is shared with the demux so both ends agree on tag width.
- Sub-module rr_arbiter holds the priority search:
  - Inputs: req[NUM_CH], rr_ptr, en.
  - Outputs: one-hot gnt[NUM_CH], binary gnt_idx, gnt_any.
- The top level holds the output register, rr_ptr update and macro handling.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0. After release the first grant is channel 0.
- Fair rotation: all 4 channels valid continuously, data 0x10/0x21/0x32/0x43, out_ready=1 -> out_sel sequence 0,1,2,3,0,... with matching data, one word per clock.
- Sparse requests: only ch2 valid (0xA5) -> out_sel=2, out_data=0xA5 one cycle later. Then only ch1 and ch3 valid -> order 3 then 1, since rr_ptr=3 after the ch2 grant.
- Backpressure: hold out_ready=0 for 5 cycles while all are valid -> out_data/out_sel stable, in_ready=0000, rr_ptr unchanged. On release, each word appears exactly once.
- Simultaneous drain and load: out_valid=1, out_ready=1, ch1 valid (0x7E) -> new word loaded the same edge, out_valid stays 1, with no bubble.
- With RR_CHANNEL_MUX_CH0_PRIO_EN defined, all channels valid -> out_sel 0,0,0... while ch0 stays valid. Drop ch0 -> 1,2,3,1,... with rr_ptr never 0.

Source files
------------

// File: rtl/rr_channel_mux_pkg.sv
// Shared definitions for the channel mux/demux pair: default sizes and the tag type.
// Both ends import this package so their channel tag widths always agree.
package mux_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int NUM_CH_DEF = 4;
   localparam int SEL_W      = $clog2(NUM_CH_DEF);

   typedef logic [SEL_W-1:0] chan_sel_t;

   // Round-robin successor of a granted channel; with skip_zero set, channel 0
   // sits outside the rotation, so the wrap goes from n-1 to 1.
   function automatic int rr_next(input int idx, input int n, input bit skip_zero);
      int nxt;
      nxt = (idx + 1) % n;
      if (skip_zero && nxt == 0) begin
         nxt = 1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/rr_channel_mux_arbiter.sv
// Combinational round-robin search: first requester at or above rr_ptr, modulo NUM_CH.
// gnt is one-hot only when en is high; gnt_idx/gnt_any report the winner regardless.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int NUM_CH = NUM_CH_DEF,
   localparam int SW     = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SW-1:0]     rr_ptr,
   input  logic              en,
   output logic [NUM_CH-1:0] gnt,
   output logic [SW-1:0]     gnt_idx,
   output logic              gnt_any
);

   logic [SW-1:0] idx;

   // NUM_CH is a power of two, so the SW-bit add wraps modulo NUM_CH for free.
   always_comb begin
      idx     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = rr_ptr + SW'(i);
         if (!gnt_any && req[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (en && gnt_any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_channel_mux.sv
// Round-robin NUM_CH-to-1 channel mux with a registered, tagged output stage.
// Optional RR_CHANNEL_MUX_CH0_PRIO_EN: channel 0 gets strict priority over the rotation.
module rr_channel_mux
   import mux_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int NUM_CH = NUM_CH_DEF,
   localparam int SW     = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SW-1:0]            out_sel,
   input  logic                     out_ready
);

   // valid/ready: a word moves on a rising edge where both valid and ready are high;
   // in_ready never depends on out_valid of a later stage beyond the load_ok term.

   logic [SW-1:0]     rr_ptr;
   logic [SW-1:0]     ptr_nxt;
   logic [NUM_CH-1:0] arb_req;
   logic [NUM_CH-1:0] arb_gnt;
   logic [SW-1:0]     arb_idx;
   logic              arb_any;
   logic              arb_en;
   logic              load_ok;
   logic [SW-1:0]     g_idx;
   logic              g_any;
   logic              take;
   logic [DATA_W-1:0] sel_data;

   assign load_ok = !out_valid || out_ready;
   assign arb_en  = load_ok && !rst;

`ifdef RR_CHANNEL_MUX_CH0_PRIO_EN
   // Channel 0 is removed from the rotation; it wins outright whenever it is valid.
   assign arb_req = {in_valid[NUM_CH-1:1], 1'b0};
`else
   assign arb_req = in_valid;
`endif

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req     (arb_req),
      .rr_ptr  (rr_ptr),
      .en      (arb_en),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   always_comb begin
      g_idx    = arb_idx;
      g_any    = arb_any;
      in_ready = arb_gnt;
`ifdef RR_CHANNEL_MUX_CH0_PRIO_EN
      if (in_valid[0]) begin
         g_idx       = '0;
         g_any       = 1'b1;
         in_ready    = '0;
         in_ready[0] = arb_en;
      end
`endif
      take = arb_en && g_any;
   end

   always_comb begin
      sel_data = in_data[int'(g_idx)*DATA_W +: DATA_W];
   end

   always_comb begin
      ptr_nxt = rr_ptr;
`ifdef RR_CHANNEL_MUX_CH0_PRIO_EN
      // A channel-0 grant leaves the rotation position untouched.
      if (g_idx != '0) begin
         ptr_nxt = SW'(rr_next(int'(g_idx), NUM_CH, 1'b1));
      end
`else
      ptr_nxt = SW'(rr_next(int'(g_idx), NUM_CH, 1'b0));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_sel   <= g_idx;
         rr_ptr    <= ptr_nxt;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_channel_mux.sv
// Directed bench for rr_channel_mux: stimulus pushes expected {sel,data} words,
// a forked monitor pops and compares each output transfer.
module tb_rr_channel_mux;

   localparam int DW = 8;
   localparam int NC = 4;
   localparam int SW = 2;

   logic             clk;
   logic             rst;
   logic [NC-1:0]    in_valid;
   logic [NC*DW-1:0] in_data;
   logic [NC-1:0]    in_ready;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic [SW-1:0]    out_sel;
   logic             out_ready;

   logic [SW+DW-1:0] exp_q[$];
   int               n_checks;
   int               n_fail;
   int               n_outs;

   rr_channel_mux dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int sel, input int data);
      exp_q.push_back({SW'(sel), DW'(data)});
   endtask

   task automatic set_data(input int d0, input int d1, input int d2, input int d3);
      in_data = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_out_data"}, 32'(out_data), 32'h0);
      check({tag, "_out_sel"}, 32'(out_sel), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SW+DW-1:0] e;
      int               exp_outs;
      n_checks = 0;
      n_fail   = 0;
      n_outs   = 0;
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got sel=%0d data=0x%0h expected none", out_sel, out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("out_word", 32'({out_sel, out_data}), 32'(e));
               end
               n_outs++;
            end
         end
      join_none

      // Reset held with every channel requesting
      set_data('h10, 'h21, 'h32, 'h43);
      in_valid  = 4'hF;
      out_ready = 1'b1;
      repeat (2) begin
         step();
         check_reset_state("reset");
      end

`ifndef RR_CHANNEL_MUX_CH0_PRIO_EN
      exp_outs = 18;
      rst = 1'b0;
      #1;
      check("first_grant", 32'(in_ready), 32'h1);

      // Fair rotation, one word per clock
      for (int i = 0; i < 8; i++) begin
         push(i % 4, 'h10 + 'h11 * (i % 4));
      end
      for (int i = 0; i < 8; i++) begin
         step();
         check("rot_valid", 32'(out_valid), 32'h1);
      end
      in_valid = '0;
      step();
      check("rot_drained", 32'(out_valid), 32'h0);

      // Sparse: ch2 alone, then ch1+ch3 with rr_ptr at 3
      set_data(0, 0, 'hA5, 0);
      in_valid = 4'b0100;
      push(2, 'hA5);
      step();
      in_valid = '0;
      check("sparse_sel", 32'(out_sel), 32'h2);
      check("sparse_data", 32'(out_data), 32'hA5);
      step();
      set_data(0, 'h5B, 0, 'hC3);
      in_valid = 4'b1010;
      push(3, 'hC3);
      push(1, 'h5B);
      #1;
      check("sparse_gnt3", 32'(in_ready), 32'h8);
      step();
      in_valid = 4'b0010;
      #1;
      check("sparse_gnt1", 32'(in_ready), 32'h2);
      step();
      in_valid = '0;
      step();

      // Backpressure: rr_ptr=2 before the load
      set_data('h10, 'h21, 'h32, 'h43);
      in_valid = 4'hF;
      push(2, 'h32);
      step();
      out_ready = 1'b0;
      #1;
      check("bp_ready0", 32'(in_ready), 32'h0);
      repeat (5) begin
         step();
         check("bp_ready", 32'(in_ready), 32'h0);
         check("bp_valid", 32'(out_valid), 32'h1);
         check("bp_sel", 32'(out_sel), 32'h2);
         check("bp_data", 32'(out_data), 32'h32);
      end
      out_ready = 1'b1;
      push(3, 'h43);
      push(0, 'h10);
      push(1, 'h21);
      #1;
      check("bp_ptr_kept", 32'(in_ready), 32'h8);
      repeat (3) step();
      in_valid = '0;
      step();

      // Simultaneous drain and load
      set_data(0, 'h7E, 'h99, 0);
      in_valid = 4'b0100;
      push(2, 'h99);
      step();
      in_valid = 4'b0010;
      push(1, 'h7E);
      #1;
      check("dl_ready", 32'(in_ready), 32'h2);
      step();
      check("dl_valid", 32'(out_valid), 32'h1);
      check("dl_sel", 32'(out_sel), 32'h1);
      check("dl_data", 32'(out_data), 32'h7E);
      in_valid = '0;
      step();
      check("drain_valid", 32'(out_valid), 32'h0);
      check("hold_data", 32'(out_data), 32'h7E);
      check("hold_sel", 32'(out_sel), 32'h1);

      // Reset while a word is held: the word is discarded and rr_ptr returns to 0
      out_ready = 1'b0;
      set_data('hE1, 0, 0, 0);
      in_valid = 4'b0001;
      step();
      in_valid = '0;
      check("mr_loaded", 32'(out_valid), 32'h1);
      rst = 1'b1;
      step();
      check_reset_state("midreset");
      rst       = 1'b0;
      out_ready = 1'b1;
      set_data('h10, 'h21, 'h32, 'h43);
      in_valid = 4'hF;
      #1;
      check("mr_ptr0", 32'(in_ready), 32'h1);
      push(0, 'h10);
      step();
      in_valid = '0;
      step();
`else
      exp_outs = 9;
      rst = 1'b0;
      #1;
      check("first_grant", 32'(in_ready), 32'h1);

      // Channel 0 wins every cycle it is valid
      repeat (4) push(0, 'h10);
      for (int i = 0; i < 4; i++) begin
         step();
         check("prio_sel", 32'(out_sel), 32'h0);
      end

      // Without channel 0 the rotation is 1,2,3,1,2
      in_valid = 4'b1110;
      push(1, 'h21);
      push(2, 'h32);
      push(3, 'h43);
      push(1, 'h21);
      push(2, 'h32);
      #1;
      check("prio_gnt1", 32'(in_ready), 32'h2);
      repeat (5) step();
      in_valid = '0;
      step();
`endif

      check("queue_empty", 32'(exp_q.size()), 32'h0);
      check("word_count", 32'(n_outs), 32'(exp_outs));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
